// File: rtl/mem_transfer_ctrl.sv
// Copies every word of memory A into memory B at the same address, one word per 3 cycles.
// Optional XFER_CHECKSUM_EN adds a running modulo-2**DATA_W sum of the written words.
module mem_transfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] DOutA,
  output logic [ADDR_W-1:0] AddrB,
  output logic              WEB,
  output logic [DATA_W-1:0] DataInB,
  output logic              busy,
  output logic              done
`ifdef XFER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    WR,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic [ADDR_W-1:0] addr_b, addr_b_d;
  logic [DATA_W-1:0] data_reg, data_d;

  // NOTE: state lives only in this block and uses non-blocking assignments, so every
  // register samples the values computed in the previous cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      addr_b   <= '0;
      data_reg <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      addr_b   <= addr_b_d;
      data_reg <= data_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    addr_b_d = addr_b;
    data_d   = data_reg;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = RD;
          idx_d   = '0;
        end
      end
      RD: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = LAT;
        end
      end
      LAT: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          data_d   = DOutA;
          addr_b_d = idx;
          state_d  = WR;
        end
      end
      WR: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (idx == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx + 1'b1;
          state_d = RD;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Write address/data are registers, so they hold their last values outside WR.
  assign AddrA   = idx;
  assign AddrB   = addr_b;
  assign DataInB = data_reg;
  assign WEB     = (state == WR);
  assign busy    = (state == RD) || (state == LAT) || (state == WR);
  assign done    = (state == DONE);

`ifdef XFER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // The WR-cycle write always completes (even with abort), so it is always summed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state == IDLE && start && !abort) begin
      sum_q <= '0;
    end else if (state == WR) begin
      sum_q <= sum_q + data_reg;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_mem_transfer_ctrl.sv
// Directed self-checking bench for mem_transfer_ctrl with behavioural memory A and B models.
// Build with +define+XFER_CHECKSUM_EN to also check the checksum output.
module tb_mem_transfer_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] AddrA, AddrB;
  logic [7:0] DOutA, DataInB;
  logic       WEB, busy, done;
`ifdef XFER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];

  int passed = 0;
  int total  = 0;

  mem_transfer_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .AddrA   (AddrA),
    .DOutA   (DOutA),
    .AddrB   (AddrB),
    .WEB     (WEB),
    .DataInB (DataInB),
    .busy    (busy),
    .done    (done)
`ifdef XFER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  // Memory A: registered read; memory B: synchronous write.
  always @(posedge clock) begin
    DOutA <= mem_a[AddrA];
    if (WEB) mem_b[AddrB] <= DataInB;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    if ({AddrA, AddrB, WEB, DataInB, busy, done} !== 22'd0) begin
      $display("FAIL reset_outputs: got %h want 0", {AddrA, AddrB, WEB, DataInB, busy, done});
    end else passed++;
    total++;
`ifdef XFER_CHECKSUM_EN
    if (checksum !== 8'h00) $display("FAIL reset_checksum: got %h want 00", checksum);
    else passed++;
    total++;
`endif
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_copy();
    logic [7:0] exp [4];
    logic [2:0] exp_ctl;
    exp[0] = 8'hFF; exp[1] = 8'h01; exp[2] = 8'h04; exp[3] = 8'h20;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = exp[i];
      mem_b[i] = 8'h00;
    end
    pulse_start();
    for (int c = 1; c <= 13; c++) begin
      exp_ctl[2] = (c % 3 == 0) && (c <= 12);
      exp_ctl[1] = (c <= 12);
      exp_ctl[0] = (c == 13);
      if ({WEB, busy, done} !== exp_ctl)
        $display("FAIL basic_ctl cycle %0d: web/busy/done got %b want %b", c, {WEB, busy, done}, exp_ctl);
      else passed++;
      total++;
      if ((c % 3 == 0) && (c <= 12)) begin
        if ({AddrB, DataInB} !== {2'(c / 3 - 1), exp[c/3-1]})
          $display("FAIL basic_wr cycle %0d: addr/data got %h want %h", c, {AddrB, DataInB},
                   {2'(c / 3 - 1), exp[c/3-1]});
        else passed++;
        total++;
      end
      tick();
    end
    if ({busy, done, WEB} !== 3'b000) $display("FAIL basic_idle: got %b want 000", {busy, done, WEB});
    else passed++;
    total++;
    for (int i = 0; i < 4; i++) begin
      if (mem_b[i] !== exp[i]) $display("FAIL basic_mem_b[%0d]: got %h want %h", i, mem_b[i], exp[i]);
      else passed++;
      total++;
    end
`ifdef XFER_CHECKSUM_EN
    if (checksum !== 8'h24) $display("FAIL basic_checksum: got %h want 24", checksum);
    else passed++;
    total++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] first [4];
    logic [7:0] second [4];
    int done_cnt;
    first[0] = 8'h00; first[1] = 8'hAA; first[2] = 8'h55; first[3] = 8'hFF;
    second[0] = 8'h12; second[1] = 8'h34; second[2] = 8'h56; second[3] = 8'h78;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = first[i];
      mem_b[i] = 8'h11;
    end
    done_cnt = 0;
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      start = (c == 5);
      if (done) begin
        done_cnt++;
        if (c != 13) $display("FAIL b2b_done_cycle: done seen in cycle %0d want 13", c);
      end
      tick();
    end
    start = 1'b0;
    if (done_cnt !== 1) $display("FAIL b2b_done_count: got %0d want 1", done_cnt);
    else passed++;
    total++;
    for (int i = 0; i < 4; i++) begin
      if (mem_b[i] !== first[i]) $display("FAIL b2b_run1_mem_b[%0d]: got %h want %h", i, mem_b[i], first[i]);
      else passed++;
      total++;
    end
`ifdef XFER_CHECKSUM_EN
    if (checksum !== 8'hFE) $display("FAIL b2b_checksum1: got %h want FE", checksum);
    else passed++;
    total++;
`endif
    for (int i = 0; i < 4; i++) mem_a[i] = second[i];
    pulse_start();
`ifdef XFER_CHECKSUM_EN
    if (checksum !== 8'h00) $display("FAIL b2b_checksum_clear: got %h want 00", checksum);
    else passed++;
    total++;
`endif
    for (int c = 1; c <= 13; c++) begin
      if (done !== (c == 13)) $display("FAIL b2b_run2_done cycle %0d: got %b want %b", c, done, (c == 13));
      else passed++;
      total++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (mem_b[i] !== second[i]) $display("FAIL b2b_run2_mem_b[%0d]: got %h want %h", i, mem_b[i], second[i]);
      else passed++;
      total++;
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp [4];
    int bad;
    mem_a[0] = 8'h5A; mem_a[1] = 8'hA5; mem_a[2] = 8'h3C; mem_a[3] = 8'hC3;
    for (int i = 0; i < 4; i++) mem_b[i] = 8'hEE;
    exp[0] = 8'h5A; exp[1] = 8'hA5; exp[2] = 8'hEE; exp[3] = 8'hEE;
    pulse_start();
    for (int c = 1; c < 8; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if ({busy, WEB, done} !== 3'b000) $display("FAIL abort_next: busy/web/done got %b want 000", {busy, WEB, done});
    else passed++;
    total++;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (WEB || done || busy) bad++;
      tick();
    end
    if (bad !== 0) $display("FAIL abort_quiet: active cycles got %0d want 0", bad);
    else passed++;
    total++;
    for (int i = 0; i < 4; i++) begin
      if (mem_b[i] !== exp[i]) $display("FAIL abort_mem_b[%0d]: got %h want %h", i, mem_b[i], exp[i]);
      else passed++;
      total++;
    end
`ifdef XFER_CHECKSUM_EN
    if (checksum !== 8'hFF) $display("FAIL abort_checksum: got %h want FF", checksum);
    else passed++;
    total++;
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp [4];
    mem_a[0] = 8'h01; mem_a[1] = 8'h02; mem_a[2] = 8'h03; mem_a[3] = 8'h04;
    for (int i = 0; i < 4; i++) mem_b[i] = 8'h00;
    pulse_start();
    for (int c = 1; c < 6; c++) tick();
    if ({WEB, busy} !== 2'b11) $display("FAIL rst_mid_wr1: web/busy got %b want 11", {WEB, busy});
    else passed++;
    total++;
    #2 reset = 1'b1;
    #1;
    if ({WEB, busy, done} !== 3'b000) $display("FAIL rst_mid_async: web/busy/done got %b want 000", {WEB, busy, done});
    else passed++;
    total++;
    tick();
    reset = 1'b0;
    tick();
    if ({mem_b[0], mem_b[1]} !== 16'h0100) $display("FAIL rst_mid_partial: got %h want 0100", {mem_b[0], mem_b[1]});
    else passed++;
    total++;
    mem_a[0] = 8'h09; mem_a[1] = 8'h08; mem_a[2] = 8'h07; mem_a[3] = 8'h06;
    exp[0] = 8'h09; exp[1] = 8'h08; exp[2] = 8'h07; exp[3] = 8'h06;
    pulse_start();
    for (int c = 1; c < 13; c++) tick();
    if (done !== 1'b1) $display("FAIL rst_mid_rerun_done: got %b want 1", done);
    else passed++;
    total++;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (mem_b[i] !== exp[i]) $display("FAIL rst_mid_mem_b[%0d]: got %h want %h", i, mem_b[i], exp[i]);
      else passed++;
      total++;
    end
`ifdef XFER_CHECKSUM_EN
    if (checksum !== 8'h1E) $display("FAIL rst_mid_checksum: got %h want 1E", checksum);
    else passed++;
    total++;
`endif
  endtask

  task automatic test_start_abort_idle();
    int bad;
    for (int i = 0; i < 4; i++) mem_b[i] = 8'h77;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    if ({busy, WEB, done} !== 3'b000) $display("FAIL sa_idle: busy/web/done got %b want 000", {busy, WEB, done});
    else passed++;
    total++;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy || WEB || done) bad++;
      tick();
    end
    for (int i = 0; i < 4; i++) if (mem_b[i] !== 8'h77) bad++;
    if (bad !== 0) $display("FAIL sa_no_activity: events got %0d want 0", bad);
    else passed++;
    total++;
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    test_start_abort_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_transfer_ctrl.md
Name: mem_transfer_ctrl

Overview:
- Transfer controller that reads every word of source memory A and writes it, at the same address, into destination memory B.
- It drives memory B's write port (AddrB/WEB/DataInB), so it is the initiator for the memoryB interface.
- Sits between memoryA and memoryB in the memory-to-memory transfer top level. Triggered by a start pulse; reports busy/done.

Parameters:
- DATA_W, 8, word width of both memories
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words transferred per run

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- abort  in  1  cancels an in-progress transfer
- AddrA  out  ADDR_W  read address to memory A
- DOutA  in  DATA_W  read data from memory A; registered in memory A, valid the cycle after AddrA is presented
- AddrB  out  ADDR_W  write address to memory B
- WEB  out  1  write enable to memory B (1 = write at next rising edge)
- DataInB  out  DATA_W  write data to memory B
- busy  out  1  high while a transfer is in progress (states RD/LAT/WR)
- done  out  1  one-cycle pulse when a transfer completes normally

Behaviour:
- Reset (async, immediate): state=IDLE, idx=0, data_reg=0; AddrA=0, AddrB=0, WEB=0, DataInB=0, busy=0, done=0.
- All outputs are decoded from registered state/idx/data_reg. There are no combinational paths from any input to any output.
- States: IDLE, RD, LAT, WR, DONE.
- IDLE: if start=1 -> RD with idx=0; else stay.
- RD: AddrA=idx -> LAT. Memory A captures the address at the end of this cycle.
- LAT: AddrA holds idx. DOutA is valid; data_reg<=DOutA at the end of the cycle -> WR.
- WR: AddrB=idx, DataInB=data_reg, WEB=1. Memory B writes at the end of this cycle.
  - If idx=DEPTH-1 -> DONE.
  - Else idx<=idx+1 -> RD.
- DONE: done=1 for exactly one cycle -> IDLE; idx<=0.
- Timing: 3 cycles per word. With start sampled at edge 0, word k is written in cycle 3k+3; DONE occurs in cycle 3*DEPTH+1 (cycle 13 for DEPTH=4).
- WEB is 1 only in WR. In all other states, WEB=0 and AddrB/DataInB hold their last values.
- idx is ADDR_W bits wide. The wrap from DEPTH-1 to 0 happens only via DONE, never by overflow inside RD/LAT/WR.
- start while busy or in DONE: ignored. It is not queued.
- abort=1 in RD/LAT/WR: next state IDLE, idx<=0, WEB=0 from the next cycle, no done pulse.
  - A write in the same WR cycle as abort still completes, because WEB was already 1 that cycle.
  - Words already written remain in B.
- abort in IDLE/DONE: no effect. DONE still pulses done.
- start and abort both high in IDLE: abort has priority; stay IDLE.
- Reset mid-transfer: immediate return to IDLE, WEB=0, no done.

Optional Feature:
- Macro XFER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (DATA_W bits).
  - checksum = modulo-2**DATA_W sum of all words written in the current run.
  - Cleared to 0 on reset and when start is accepted; accumulated with DataInB in each WR cycle.
  - Holds its value after DONE or abort until the next accepted start.
- Undefined: no checksum port, no adder; all other behaviour identical.

Test Plan:
- Basic copy: A={FF,01,04,20}, pulse start -> B={FF,01,04,20}; WEB high in cycles 3,6,9,12; done=1 only in cycle 13; busy=1 in cycles 1-12.
- Back-to-back: A={00,AA,55,FF}, second start issued in cycle 5 -> ignored, single done; then start after DONE -> second full run, done again 13 cycles later.
- Abort: abort=1 during LAT of word 2 -> B words 0,1 updated, words 2,3 unchanged, WEB never high again, done never pulses, busy=0 next cycle.
- Reset mid-run: assert reset asynchronously during WR of word 1 (between edges) -> WEB/busy drop immediately; after release, start yields correct full copy.
- Simultaneous start+abort in IDLE -> stays IDLE, busy=0, no writes.
- XFER_CHECKSUM_EN: A={FF,01,04,20} -> checksum=0x24 after DONE; reset to 0 on the next start.
